// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: segment code table,
// segment bit positions, FSM state type and select-pattern helpers.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-low segment codes indexed by nibble value, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_t;

  function automatic logic sel_valid(input logic [7:0] sel);
    return $onehot(~sel);
  endfunction

  function automatic logic [2:0] sel_index(input logic [7:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!sel[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of a 7-bit active-low segment pattern to its hex nibble.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       match,
  output logic [3:0] nibble
);

  // Codes are unique, so at most one entry can hit; dp is forced off on both sides.
  always_comb begin
    match  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if ({1'b1, seg} == (SEG_CODES[i] | 8'h80)) begin
        match  = 1'b1;
        nibble = i[3:0];
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs the 32-bit word shown on a multiplexed 8-digit 7-segment
// display by sniffing the driver's segment and digit-select lines.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  o_seg,
  input  logic [7:0]  o_sel,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        frame_done,
  output logic        frame_err,
  output logic        stable,
  output logic [7:0]  digit_mask
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int KW = $clog2(STABLE_FRAMES + 1);

  logic [7:0]    seg_q;
  logic [7:0]    sel_q;
  logic [7:0]    cur_sel_q, cur_sel_d;
  scan_state_t   state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] tmo_cnt_q;
  logic [KW-1:0] stable_cnt_q;
  logic [31:0]   word_q;
  logic          err_flag_q;
  logic          capture;
  logic          seg_match;
  logic [3:0]    seg_nibble;
  logic [2:0]    cap_idx;
  logic          frame_complete;
  logic          timeout_hit;
  logic [7:0]    base_mask;
  logic          base_err;
  logic          unused_dp;

  assign unused_dp = seg_q[SEG_DP];

  seg7_pattern_decode u_decode (
    .seg    (seg_q[SEG_G:SEG_A]),
    .match  (seg_match),
    .nibble (seg_nibble)
  );

  // Any invalid select drops back to IDLE; a new valid select always restarts settling.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    cur_sel_d    = cur_sel_q;
    capture      = 1'b0;
    if (!sel_valid(sel_q)) begin
      state_d      = IDLE;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = SETTLE;
          settle_cnt_d = SW'(1);
          cur_sel_d    = sel_q;
        end
        SETTLE: begin
          if (sel_q != cur_sel_q) begin
            settle_cnt_d = SW'(1);
            cur_sel_d    = sel_q;
          end else if (settle_cnt_q >= SW'(SETTLE_CYCLES - 1)) begin
            state_d      = HELD;
            settle_cnt_d = '0;
            capture      = 1'b1;
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end
        end
        HELD: begin
          if (sel_q != cur_sel_q) begin
            state_d      = SETTLE;
            settle_cnt_d = SW'(1);
            cur_sel_d    = sel_q;
          end
        end
        default: begin
          state_d      = IDLE;
          settle_cnt_d = '0;
        end
      endcase
    end
  end

  assign cap_idx        = sel_index(sel_q);
  assign frame_complete = (digit_mask == 8'hFF);
  assign timeout_hit    = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign base_mask      = frame_complete ? 8'h00 : digit_mask;
  assign base_err       = frame_complete ? 1'b0 : err_flag_q;
  assign stable         = (stable_cnt_q >= KW'(STABLE_FRAMES));

  // A capture in the completing cycle starts the next frame rather than being lost.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      seg_q        <= '0;
      sel_q        <= '0;
      cur_sel_q    <= '0;
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      stable_cnt_q <= '0;
      word_q       <= '0;
      err_flag_q   <= 1'b0;
      digit_mask   <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      seg_q        <= o_seg;
      sel_q        <= o_sel;
      cur_sel_q    <= cur_sel_d;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      frame_done   <= frame_complete;
      frame_err    <= frame_complete & err_flag_q;

      if (frame_complete && !err_flag_q) begin
        value       <= word_q;
        value_valid <= 1'b1;
        if (value_valid && (word_q == value)) begin
          if (stable_cnt_q < KW'(STABLE_FRAMES)) stable_cnt_q <= stable_cnt_q + KW'(1);
        end else begin
          stable_cnt_q <= KW'(1);
        end
      end

      if (capture) begin
        digit_mask                  <= base_mask | (8'(1) << cap_idx);
        err_flag_q                  <= base_err | ~seg_match;
        word_q[{cap_idx, 2'b00} +: 4] <= seg_match ? seg_nibble : 4'h0;
        tmo_cnt_q                   <= '0;
      end else if (timeout_hit) begin
        digit_mask <= '0;
        err_flag_q <= 1'b0;
        tmo_cnt_q  <= '0;
      end else begin
        digit_mask <= base_mask;
        err_flag_q <= base_err;
        tmo_cnt_q  <= tmo_cnt_q + TW'(1);
      end
    end
  end

endmodule
